// File: rtl/mem_arbiter_if.sv
// Requester and SRAM-side signal bundle for mem_arbiter.
// The arbiter uses the slave modport; the requesters and SRAM side use master.
interface mem_arbiter_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_we;
    logic [NUM_REQ*32-1:0] req_addr;
    logic [NUM_REQ*4-1:0]  req_width;
    logic [NUM_REQ*32-1:0] req_wdata;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ-1:0]    rsp_valid;
    logic [31:0]           rsp_rdata;
    logic                  rsp_err;
    logic                  mem_ce;
    logic                  mem_we;
    logic [31:0]           mem_addr;
    logic [3:0]            mem_width;
    logic [31:0]           mem_wdata;
    logic [31:0]           mem_rdata;

    modport slave (
        input  req_valid, req_we, req_addr, req_width, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               mem_ce, mem_we, mem_addr, mem_width, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_addr, req_width, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               mem_ce, mem_we, mem_addr, mem_width, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one SRAM load/store port among NUM_REQ requesters.
// One transaction in flight: IDLE -> ACCEPT -> ISSUE (SRAM_LAT cycles) -> RESP.
module mem_arbiter #(
    parameter int NUM_REQ  = 2,
    parameter int SRAM_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    localparam int PW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, ACCEPT, ISSUE, RESP} state_t;

    state_t        state, state_nx;
    logic [PW-1:0] rr, gnt, g_q, idx;
    logic          any_vld;
    logic          sel_we;
    logic [31:0]   sel_addr, sel_wdata;
    logic [3:0]    sel_width;
    logic          lat_we;
    logic [31:0]   lat_addr, lat_wdata;
    logic [3:0]    lat_width;
    logic          err_q;
    logic [2:0]    cnt;
    logic [31:0]   rdata_q;
    logic          legal;
    logic          issue_last;

    // Search order rr, rr+1, .. with wrap; descending loop so the lowest offset wins.
    always_comb begin
        any_vld = 1'b0;
        gnt     = rr;
        idx     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = PW'((int'(rr) + k) % NUM_REQ);
            if (bus.req_valid[idx]) begin
                any_vld = 1'b1;
                gnt     = idx;
            end
        end
    end

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_width = '0;
        sel_wdata = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (PW'(r) == gnt) begin
                sel_we    = bus.req_we[r];
                sel_addr  = bus.req_addr[32*r +: 32];
                sel_width = bus.req_width[4*r +: 4];
                sel_wdata = bus.req_wdata[32*r +: 32];
            end
        end
    end

    always_comb begin
        case (lat_width)
            4'd1:    legal = 1'b1;
            4'd2:    legal = ~lat_addr[0];
            4'd4:    legal = (lat_addr[1:0] == 2'b00);
            default: legal = 1'b0;
        endcase
    end

    assign issue_last = (cnt == 3'(SRAM_LAT - 1));

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (any_vld) state_nx = ACCEPT;
            ACCEPT:  state_nx = legal ? ISSUE : RESP;
            ISSUE:   if (issue_last) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = '0;
        bus.rsp_valid = '0;
        bus.rsp_err   = 1'b0;
        bus.rsp_rdata = '0;
        bus.mem_ce    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_width = '0;
        bus.mem_wdata = '0;
        if (state == IDLE && any_vld) bus.req_ready[gnt] = 1'b1;
        if (state == RESP) begin
            bus.rsp_valid[g_q] = 1'b1;
            bus.rsp_err        = err_q;
            bus.rsp_rdata      = rdata_q;
        end
        if (state == ISSUE) begin
            bus.mem_ce    = 1'b1;
            bus.mem_we    = lat_we;
            bus.mem_addr  = lat_addr;
            bus.mem_width = lat_width;
            bus.mem_wdata = lat_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rr        <= '0;
            g_q       <= '0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_width <= '0;
            lat_wdata <= '0;
            err_q     <= 1'b0;
            cnt       <= '0;
            rdata_q   <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (any_vld) begin
                    g_q       <= gnt;
                    lat_we    <= sel_we;
                    lat_addr  <= sel_addr;
                    lat_width <= sel_width;
                    lat_wdata <= sel_wdata;
                    err_q     <= 1'b0;
                    cnt       <= '0;
                    rdata_q   <= '0;
                end
                ACCEPT: err_q <= ~legal;
                ISSUE: begin
                    cnt <= cnt + 3'd1;
                    // Stores leave rdata_q at the zero loaded on accept.
                    if (issue_last && !lat_we) rdata_q <= bus.mem_rdata;
                end
                RESP: rr <= (int'(g_q) == NUM_REQ - 1) ? '0 : g_q + 1'b1;
                default: ;
            endcase
        end
    end
endmodule
